// File: rtl/rssb_mem_arbiter.sv
// Single-port RAM arbiter between the RSSB core (CPU port) and the loader/debug port (LD port).
// Define RSSB_ARB_RR_EN for round-robin arbitration; default is fixed LD-over-CPU priority.
module rssb_mem_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LD  = 1'b1;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  logic [0:0] state;
  logic [2:0] lat_cnt;
  logic       owner;
  logic       idle;
  logic       pick_ld;

`ifdef RSSB_ARB_RR_EN
  logic       last_owner;
`endif

  always_comb begin
    // Grants are also blocked while reset is asserted, not only by the IDLE state.
    idle = rst && (state == IDLE);
`ifdef RSSB_ARB_RR_EN
    pick_ld = ld_req && (!cpu_req || (last_owner == OWN_CPU));
`else
    pick_ld = ld_req;
`endif
    ld_gnt    = idle && pick_ld;
    cpu_gnt   = idle && cpu_req && !pick_ld;
    mem_en    = ld_gnt || cpu_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_gnt) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
    cpu_stall = (cpu_req && !cpu_gnt)
             || (cpu_gnt && !cpu_we)
             || ((state == WAIT) && (owner == OWN_CPU));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      owner      <= OWN_CPU;
      cpu_rvalid <= 1'b0;
      ld_rvalid  <= 1'b0;
      cpu_rdata  <= '0;
      ld_rdata   <= '0;
    end else begin
      cpu_rvalid <= 1'b0;
      ld_rvalid  <= 1'b0;
      if (state == IDLE) begin
        if (mem_en && !mem_we) begin
          state   <= WAIT;
          lat_cnt <= LAT_INIT;
          owner   <= ld_gnt ? OWN_LD : OWN_CPU;
        end
      end else begin
        lat_cnt <= lat_cnt - 3'd1;
        if (lat_cnt == 3'd1) begin
          state <= IDLE;
          if (owner == OWN_LD) begin
            ld_rdata  <= mem_rdata;
            ld_rvalid <= 1'b1;
          end else begin
            cpu_rdata  <= mem_rdata;
            cpu_rvalid <= 1'b1;
          end
        end
      end
    end
  end

`ifdef RSSB_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner <= OWN_CPU;
    end else if (mem_en) begin
      last_owner <= ld_gnt ? OWN_LD : OWN_CPU;
    end
  end
`endif

endmodule

// File: tb/tb_rssb_mem_arbiter.sv
// Self-checking bench for rssb_mem_arbiter: vector table, directed multi-cycle sequences,
// and a read-data scoreboard fed from a latency-accurate RAM model.
module tb_rssb_mem_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req, cpu_we, ld_req, ld_we;
  logic [AW-1:0] cpu_addr, ld_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, ld_wdata, mem_wdata, mem_rdata, cpu_rdata, ld_rdata;
  logic          cpu_gnt, cpu_rvalid, cpu_stall, ld_gnt, ld_rvalid, mem_en, mem_we;

  rssb_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed { logic ld; logic [7:0] data; } sb_t;
  sb_t sb_q[$];

  logic [7:0] model [256];
  logic [7:0] ram   [256];
  logic [7:0] rd_pipe [LAT];

  // RAM model: read data is valid LAT cycles after the strobe, garbage otherwise.
  always @(posedge clk) begin
    rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : 8'hEE;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
  end
  assign mem_rdata = rd_pipe[LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (rst && (cpu_rvalid || ld_rvalid)) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: rvalid cpu=%0b ld=%0b, expected none", cpu_rvalid, ld_rvalid);
      end else begin
        e = sb_q.pop_front();
        check("sb_port", {30'd0, cpu_rvalid, ld_rvalid}, e.ld ? 32'd1 : 32'd2);
        check("sb_rdata", e.ld ? ld_rdata : cpu_rdata, e.data);
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_req  = 0; ld_we  = 0; ld_addr  = '0; ld_wdata  = '0;
  endtask

  task automatic drv_cpu(input logic we, input logic [7:0] a, input logic [7:0] d);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drv_ld(input logic we, input logic [7:0] a, input logic [7:0] d);
    ld_req = 1; ld_we = we; ld_addr = a; ld_wdata = d;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (sb_q.size() != 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    check(name, sb_q.size(), 0);
  endtask

  task automatic do_reset();
    next();
    rst = 0;
    idle_in();
    next();
    next();
    rst = 1;
  endtask

  typedef struct {
    logic cr, cw; logic [7:0] ca, cd;
    logic lr, lw; logic [7:0] la, ldd;
    logic [4:0] ectl; logic [7:0] eaddr, ewd;
  } vec_t;
  vec_t vt [8];

  initial begin
    // ectl = {cpu_gnt, ld_gnt, mem_en, mem_we, cpu_stall}
    vt[0] = '{1'b0, 1'b1, 8'h44, 8'h99, 1'b0, 1'b0, 8'h00, 8'h00, 5'b00000, 8'h00, 8'h00};
    vt[1] = '{1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 5'b10110, 8'h10, 8'hA5};
    vt[2] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h33, 8'h77, 5'b01110, 8'h33, 8'h77};
    vt[3] = '{1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 5'b10101, 8'h22, 8'h00};
    vt[4] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 5'b01100, 8'h10, 8'h00};
    vt[5] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h23, 8'h3C, 5'b01110, 8'h23, 8'h3C};
    vt[6] = '{1'b1, 1'b0, 8'h23, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 5'b10101, 8'h23, 8'h00};
    vt[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h33, 8'h00, 5'b01100, 8'h33, 8'h00};

    for (int i = 0; i < 256; i++) begin
      model[i] = 8'(i * 7 + 3);
      ram[i]   = model[i];
    end
    model[8'h22] = 8'h5C;
    ram[8'h22]   = 8'h5C;

    // Reset with both ports requesting: everything must stay quiet.
    rst = 0;
    drv_cpu(1'b1, 8'h10, 8'hA5);
    drv_ld(1'b1, 8'h20, 8'h5A);
    repeat (2) @(posedge clk);
    smp();
    check("rst_gnt_en", {28'd0, cpu_gnt, ld_gnt, mem_en, mem_we}, 0);
    check("rst_rvalid", {30'd0, cpu_rvalid, ld_rvalid}, 0);
    check("rst_mem_bus", {16'd0, mem_addr, mem_wdata}, 0);
    check("rst_rdata", {16'd0, cpu_rdata, ld_rdata}, 0);
    idle_in();
    #2 rst = 1;

    for (int r = 0; r < 8; r++) begin
      next();
      cpu_req = vt[r].cr; cpu_we = vt[r].cw; cpu_addr = vt[r].ca; cpu_wdata = vt[r].cd;
      ld_req  = vt[r].lr; ld_we  = vt[r].lw; ld_addr  = vt[r].la; ld_wdata  = vt[r].ldd;
      smp();
      check($sformatf("vec%0d", r), {11'd0, cpu_gnt, ld_gnt, mem_en, mem_we, cpu_stall, mem_addr, mem_wdata},
            {11'd0, vt[r].ectl, vt[r].eaddr, vt[r].ewd});
      if (vt[r].lr) begin
        if (vt[r].lw) model[vt[r].la] = vt[r].ldd;
        else sb_q.push_back('{1'b1, model[vt[r].la]});
      end else if (vt[r].cr) begin
        if (vt[r].cw) model[vt[r].ca] = vt[r].cd;
        else sb_q.push_back('{1'b0, model[vt[r].ca]});
      end
      next();
      idle_in();
      if ((vt[r].lr && !vt[r].lw) || (vt[r].cr && !vt[r].cw)) drain($sformatf("vec%0d_rvalid_timeout", r));
    end

    // Back-to-back CPU writes: a grant is possible on the very next cycle.
    next();
    drv_cpu(1'b1, 8'h10, 8'hA5);
    smp();
    check("wr0_bus", {13'd0, cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata}, {13'd0, 3'b111, 8'h10, 8'hA5});
    model[8'h10] = 8'hA5;
    next();
    drv_cpu(1'b1, 8'h11, 8'h5A);
    smp();
    check("wr1_bus", {13'd0, cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata}, {13'd0, 3'b111, 8'h11, 8'h5A});
    model[8'h11] = 8'h5A;
    next();
    idle_in();

    // CPU read with latency 3: grant at T, data at T+4.
    next();
    drv_cpu(1'b0, 8'h22, 8'h00);
    smp();
    check("rd_T_gnt_stall", {30'd0, cpu_gnt, cpu_stall}, 3);
    sb_q.push_back('{1'b0, 8'h5C});
    for (int k = 1; k <= LAT; k++) begin
      next();
      idle_in();
      smp();
      check($sformatf("rd_T%0d_stall", k), {31'd0, cpu_stall}, 1);
      check($sformatf("rd_T%0d_quiet", k), {29'd0, mem_en, cpu_gnt, cpu_rvalid}, 0);
    end
    next();
    smp();
    check("rd_rvalid", {23'd0, cpu_rvalid, cpu_rdata}, {23'd0, 1'b1, 8'h5C});
    check("rd_stall_low", {31'd0, cpu_stall}, 0);
    next();
    smp();
    check("rd_hold", {23'd0, cpu_rvalid, cpu_rdata}, {23'd0, 1'b0, 8'h5C});

    // Contention from a fresh reset (last owner = CPU).
    do_reset();
    next();
    drv_cpu(1'b1, 8'h50, 8'h11);
    drv_ld(1'b1, 8'h60, 8'h22);
    smp();
    check("contest_ld_first", {29'd0, ld_gnt, cpu_gnt, cpu_stall}, 3'b101);
    model[8'h60] = 8'h22;
    next();
    ld_req = 0;
    smp();
    check("contest_cpu_next", {29'd0, ld_gnt, cpu_gnt, cpu_stall}, 3'b010);
    model[8'h50] = 8'h11;
    next();
    idle_in();
    for (int k = 0; k < 4; k++) begin
      logic exp_ld;
`ifdef RSSB_ARB_RR_EN
      exp_ld = (k % 2 == 0);
`else
      exp_ld = 1'b1;
`endif
      next();
      drv_cpu(1'b1, 8'h70, 8'hC1);
      drv_ld(1'b1, 8'h80, 8'hD2);
      smp();
      check($sformatf("contest%0d", k), {29'd0, ld_gnt, cpu_gnt, cpu_stall}, {29'd0, exp_ld, !exp_ld, exp_ld});
      if (exp_ld) model[8'h80] = 8'hD2;
      else model[8'h70] = 8'hC1;
    end
    next();
    idle_in();

    // Reset in the middle of an LD read wait.
    next();
    drv_ld(1'b0, 8'h40, 8'h00);
    smp();
    check("rstw_ld_gnt", {31'd0, ld_gnt}, 1);
    next();
    idle_in();
    #2 rst = 0;
    smp();
    check("rstw_during", {22'd0, ld_rvalid, mem_en, ld_rdata}, 0);
    next();
    next();
    rst = 1;
    drv_cpu(1'b1, 8'h41, 8'h66);
    smp();
    check("rstw_cpu_gnt", {30'd0, cpu_gnt, mem_en}, 3);
    model[8'h41] = 8'h66;
    next();
    idle_in();
    for (int k = 0; k < LAT + 2; k++) begin
      smp();
      check($sformatf("rstw_no_rvalid%0d", k), {23'd0, ld_rvalid, ld_rdata}, 0);
      next();
    end

    // LD read completes in the same cycle a waiting CPU write is granted.
    drv_ld(1'b0, 8'h33, 8'h00);
    smp();
    check("b2b_ld_gnt", {31'd0, ld_gnt}, 1);
    sb_q.push_back('{1'b1, model[8'h33]});
    for (int k = 1; k <= LAT; k++) begin
      next();
      ld_req = 0;
      drv_cpu(1'b1, 8'h90, 8'h42);
      smp();
      check($sformatf("b2b_wait%0d", k), {30'd0, cpu_gnt, cpu_stall}, 1);
    end
    next();
    smp();
    check("b2b_rvalid_gnt", {29'd0, ld_rvalid, cpu_gnt, cpu_stall}, 3'b110);
    model[8'h90] = 8'h42;
    next();
    idle_in();

    drain("final_drain");
    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rssb_mem_arbiter.md
Name: rssb_mem_arbiter

Overview:
- Shares the single-port data/program RAM of the RSSB core between two requesters: the core's control FSM (CPU port) and the external program loader/debug port (LD port).
- Arbitrates requests, issues one memory access at a time and tracks the read latency.
- Returns read data to the owner and produces a stall signal, so the core's control sequencer holds its state while it waits.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- MEM_LAT, 1, RAM read latency in cycles; legal values are 1 to 7.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  one-cycle grant pulse
- cpu_rvalid  out  1  one-cycle read-data-valid pulse
- cpu_rdata  out  DW  registered read data
- cpu_stall  out  1  = cpu_req & ~cpu_gnt, OR a CPU read is outstanding
- ld_req, ld_we, ld_addr, ld_wdata, ld_gnt, ld_rvalid, ld_rdata: same meaning as the CPU port, for the loader
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset is asynchronous and active-low (rst = 0). During reset:
  - state = IDLE, lat_cnt = 0, owner = CPU, last_owner = CPU;
  - cpu_rvalid = ld_rvalid = 0, cpu_rdata = ld_rdata = 0.
  - All mem_* outputs and grants are 0.
- Reset mid-read aborts the read: no rvalid is produced afterwards.
- States: IDLE and WAIT.
- IDLE:
  - If any request is present, the winner is chosen combinationally.
  - In the same cycle the block asserts the winner's gnt, mem_en = 1, and drives mem_we/mem_addr/mem_wdata from the winner's port.
  - A write completes in that cycle; state stays IDLE, so a new grant is possible on the next cycle.
  - A read loads lat_cnt = MEM_LAT, records owner, and moves to WAIT.
  - With no request: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- WAIT:
  - No grants; mem_en = 0; lat_cnt decrements each cycle.
  - In the cycle where lat_cnt == 1, mem_rdata is registered into owner_rdata, and the state returns to IDLE.
  - In the next cycle, owner_rvalid = 1 for exactly one cycle.
- Read latency: a grant in cycle T gives rvalid and data in cycle T+MEM_LAT+1.
- A new grant may issue in the same cycle as rvalid.
- Priority (default): fixed, LD over CPU. Simultaneous requests in IDLE → LD is granted and the CPU stalls.
- rdata holds its last value after rvalid drops.
- last_owner updates on every grant.
- Requester rules:
  - req, we, addr and wdata must be stable from req rise until gnt.
  - A requester deasserts req or presents its next access in the cycle after gnt.
  - Dropping req before gnt is allowed; no access results.
- cpu_stall covers two cases:
  - CPU requesting and not granted this cycle;
  - CPU read in WAIT, including the transfer cycle before rvalid.
  - cpu_stall is low in the rvalid cycle.
- Exactly one gnt is asserted at most in any cycle, and never while in WAIT.

Optional Feature:
- Macro: RSSB_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On a simultaneous request, the port that is not last_owner wins.
  - A lone requester always wins.
- Undefined: fixed LD-over-CPU priority; the last_owner register may be optimised away.

Test Plan:
- CPU write with MEM_LAT=1: cpu_req=1, cpu_we=1, addr=0x10, wdata=0xA5.
  - Same cycle: cpu_gnt=1, mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xA5.
  - Next cycle: a new grant is possible.
- CPU read, MEM_LAT=3: grant in cycle T with addr=0x22; RAM returns 0x5C.
  - cpu_rvalid=1 and cpu_rdata=0x5C in T+4.
  - cpu_stall high T..T+3 and low at T+4.
  - No mem_en during T+1..T+3.
- Simultaneous cpu_req and ld_req in IDLE, default build.
  - ld_gnt first and cpu_stall=1; CPU granted on the next IDLE cycle.
  - Repeating with ld_req always high starves the CPU.
- Same stimulus with RSSB_ARB_RR_EN defined.
  - Grants alternate LD, CPU, LD, CPU over 4 contested write accesses.
- rst pulled low mid-WAIT of an LD read, then released.
  - No ld_rvalid and ld_rdata=0; state is IDLE.
  - A CPU request on the first cycle after release is granted immediately.
- Back-to-back: LD read rvalid cycle coincides with a waiting cpu_req write.
  - ld_rvalid=1 and cpu_gnt=1 in the same cycle.
